// File: rtl/memory_control.sv
// -----------------------------------------------------------------------------
// memory_control
//
// Arbitrates between the CPU instruction-fetch port and data port for a single
// shared RAM. A request is seen in IDLE, the RAM is driven in IACC/DACC until
// it reports ACCESS or ERROR, and the matching wait line drops for exactly one
// cycle in IRESP/DRESP. Address, write data and operation are latched at grant
// and stay fixed until the response, whatever the CPU does meanwhile.
//
// Configuration macro:
//   MEMCTL_RR_EN  defined   : round-robin between the instruction and data sides
//                 undefined : a data request always wins (fixed priority)
//
// Ports:
//   CLK, RST          rising-edge clock, asynchronous active-high reset
//   iREN, iaddr       instruction read request and address
//   iload, iwait      instruction data, low for one cycle when it is ready
//   dREN, dWEN        data read / write enables (both high = write)
//   daddr, dstore     data address and write data
//   dload, dwait      data read result, low for one cycle when ready
//   ramREN, ramWEN    RAM read / write enables (never both)
//   ramaddr, ramstore RAM word address and write data
//   ramload, ramstate RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err               sticky RAM-error flag, cleared only by reset
// -----------------------------------------------------------------------------
module memory_control (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IACC  = 3'd1,
    DACC  = 3'd2,
    IRESP = 3'd3,
    DRESP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RAM_FREE   = 2'd0,
    RAM_BUSY   = 2'd1,
    RAM_ACCESS = 2'd2,
    RAM_ERROR  = 2'd3
  } ram_state_t;

  localparam logic [31:0] ERR_WORD = 32'hBAD1_BAD1;

  state_t state;
  logic   data_req;
  logic   grant_data;

  // Address bits [1:0] are forced to zero on the RAM side, so they are unused.
  logic   unused_addr_bits;
  assign unused_addr_bits = ^{iaddr[1:0], daddr[1:0]};

  assign data_req = dREN | dWEN;

`ifdef MEMCTL_RR_EN
  // High when the data side was granted most recently; on a tie the other
  // side wins. Reset value 0 means "instruction last", so data wins first.
  logic last_data;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    grant_data = 1'b0;
`ifdef MEMCTL_RR_EN
    grant_data = data_req & (~iREN | ~last_data);
`else
    grant_data = data_req;
`endif
  end

  // Wait lines decode the state directly so they fall in the RESP cycle itself.
  assign iwait = (state != IRESP);
  assign dwait = (state != DRESP);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      ramREN    <= 1'b0;
      ramWEN    <= 1'b0;
      ramaddr   <= '0;
      ramstore  <= '0;
      iload     <= '0;
      dload     <= '0;
      err       <= 1'b0;
`ifdef MEMCTL_RR_EN
      last_data <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            state    <= DACC;
            ramaddr  <= {daddr[31:2], 2'b00};
            ramstore <= dstore;
            // A simultaneous read and write enable is treated as a write.
            ramWEN   <= dWEN;
            ramREN   <= ~dWEN;
`ifdef MEMCTL_RR_EN
            last_data <= 1'b1;
`endif
          end else if (iREN) begin
            state    <= IACC;
            ramaddr  <= {iaddr[31:2], 2'b00};
            ramstore <= dstore;
            ramWEN   <= 1'b0;
            ramREN   <= 1'b1;
`ifdef MEMCTL_RR_EN
            last_data <= 1'b0;
`endif
          end
        end

        IACC, DACC: begin
          case (ram_state_t'(ramstate))
            RAM_ACCESS: begin
              // ramWEN still holds the latched op, so writes never touch dload.
              if (state == IACC)
                iload <= ramload;
              else if (!ramWEN)
                dload <= ramload;
              ramREN <= 1'b0;
              ramWEN <= 1'b0;
              state  <= (state == IACC) ? IRESP : DRESP;
            end
            RAM_ERROR: begin
              err <= 1'b1;
              if (state == IACC)
                iload <= ERR_WORD;
              else
                dload <= ERR_WORD;
              ramREN <= 1'b0;
              ramWEN <= 1'b0;
              state  <= (state == IACC) ? IRESP : DRESP;
            end
            default: begin
              // FREE or BUSY: keep driving the latched request.
            end
          endcase
        end

        IRESP, DRESP: begin
          state <= IDLE;
        end

        default: begin
          state  <= IDLE;
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_control.md
MEMORY_CONTROL -- requirements
Module: memory_control

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset (one clock; reset is asynchronous and active-high).
REQ-002 SHALL have port: CLK  in  1  rising-edge clock.
REQ-003 SHALL have port: RST  in  1  asynchronous active-high reset.
REQ-004 SHALL have port: iREN  in  1  instruction read request, driven by the CPU instruction-fetch read enable (imemREN).
REQ-005 SHALL have port: iaddr  in  32  instruction address.
REQ-006 SHALL have ports: iload  out  32  instruction data; iwait  out  1  high until the instruction response is ready.
REQ-007 SHALL have ports: dREN  in  1 and dWEN  in  1, the CPU data read/write enables (dmemREN/dmemWEN).
REQ-008 SHALL have ports: daddr  in  32  data address; dstore  in  32  write data.
REQ-009 SHALL have ports: dload  out  32  read data; dwait  out  1  high until the data response is ready.
REQ-010 SHALL have ports: ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32.
REQ-011 SHALL have ports: ramload  in  32; ramstate  in  2  (FREE=0, BUSY=1, ACCESS=2, ERROR=3).
REQ-012 SHALL have port: err  out  1  sticky RAM-error flag.

Function
REQ-013 SHALL implement FSM states IDLE, IACC, DACC, IRESP, DRESP.
REQ-014 IDLE: if (dREN|dWEN), or iREN is asserted, SHALL latch the address (bits [1:0] forced to 0), dstore, and the op, then go to DACC/IACC next cycle; with no request, SHALL stay in IDLE.
REQ-015 dREN and dWEN high together SHALL be treated as a write.
REQ-016 Both iREN and a data request in IDLE SHALL be arbitrated per REQ-030/REQ-031.
REQ-017 IACC/DACC: ramaddr and ramstore SHALL come from latched registers; ramREN=1 for reads, ramWEN=1 for writes, never both.
REQ-018 IACC/DACC: ramstate FREE or BUSY SHALL hold the state; ACCESS SHALL capture ramload into the load register of the granted side (no capture on writes) and go to the matching RESP state.
REQ-019 IACC/DACC: ramstate ERROR SHALL set err, load 32'hBAD1BAD1 into the granted side's load register, and go to the matching RESP state.
REQ-020 IRESP/DRESP: ram enables SHALL be 0, iwait (resp. dwait) SHALL be 0 for exactly one cycle, and the next state SHALL be IDLE.
REQ-021 iwait = ~(state==IRESP); dwait = ~(state==DRESP); both combinational from state only.
REQ-022 Minimum latency SHALL be 2 cycles: request seen in IDLE at cycle N, RAM ACCESS at N+1, wait low at N+2.
REQ-023 iload/dload SHALL hold their last value until overwritten by the next completed access to the same side.
REQ-024 A request dropped after grant SHALL NOT abort the RAM transaction; the RESP pulse still occurs; a request dropped before grant SHALL have no effect.
REQ-025 Latched address, data and op SHALL NOT change between grant and RESP, regardless of input changes.

Reset
REQ-026 RST high SHALL immediately force state=IDLE, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0, err=0, iwait=1, dwait=1, and SHALL clear the arbitration pointer to "data first".
REQ-027 Reset mid-access SHALL abandon the transaction with no RESP pulse after reset release.
REQ-028 err SHALL clear only on reset.

Configuration
REQ-029 The macro MEMCTL_RR_EN SHALL select the arbitration policy.
REQ-030 MEMCTL_RR_EN undefined: a data request SHALL always win over iREN (fixed priority).
REQ-031 MEMCTL_RR_EN defined: on a simultaneous request, the side not granted last SHALL win; the 1-bit last-grant pointer SHALL update on every grant and reset to "instruction last" (data wins first).

Verification
REQ-032 iREN=1, iaddr=0x00000043, ramstate=ACCESS immediately, ramload=0x3C010001 -> ramaddr=0x40, ramREN=1 at N+1; iwait=0 and iload=0x3C010001 at N+2 only.
REQ-033 dWEN=1, daddr=0x80, dstore=0xDEADBEEF, ramstate BUSY for 3 cycles then ACCESS -> ramWEN=1 with ramstore=0xDEADBEEF for 4 cycles; dwait=0 one cycle later; dload unchanged.
REQ-034 iREN=dREN=1 held across two transactions -> undefined macro: data served twice with instruction starved; defined: order D, I, D.
REQ-035 dREN=1, ramstate=ERROR in DACC -> err=1 sticky, dload=0xBAD1BAD1, dwait low one cycle, next access still completes normally.
REQ-036 RST pulsed while in DACC with ramWEN=1 -> ramWEN=0 in the same cycle (asynchronously), all outputs at reset values, no dwait pulse after release.
